// File: rtl/hyp_pkg.sv
// Shared types and constants for the hypotenuse sequencer (hyp_seq_ctrl / hyp_isqrt).
package hyp_pkg;

  localparam int unsigned W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQX  = 3'd1,
    SQY  = 3'd2,
    SQRT = 3'd3,
    DONE = 3'd4
  } hyp_state_e;

  // Enabled edges from the accepting edge to the first DONE cycle.
  function automatic int unsigned hyp_lat(input int unsigned w);
    return 3 * w + 1;
  endfunction

  localparam int unsigned LAT_DEF = hyp_lat(W_DEF);

endpackage

// File: rtl/hyp_isqrt.sv
// Bit-serial restoring square root: i_load captures a 2W+1-bit radicand, each i_step
// retires one root bit MSB first; after W+1 steps o_root_nxt_c holds the full root.
module hyp_isqrt
  import hyp_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [2*W:0] i_rad,
  input  logic         i_step,
  output logic [W:0]   o_root_nxt_c
);

  localparam int unsigned RW   = 2 * W + 2;
  localparam int unsigned REMW = W + 3;
  localparam int unsigned TW   = REMW + 2;

  logic [RW-1:0]   r_rad;
  logic [REMW-1:0] r_rem;
  logic [W-1:0]    r_root;

  logic [TW-1:0]   w_trial;
  logic [TW-1:0]   w_sub;
  logic            w_ge;
  logic [REMW-1:0] w_rem_nxt;
  logic [W:0]      w_root_nxt;

  // One restoring digit: bring down two radicand bits, try subtracting 4*root+1.
  always_comb begin
    w_trial    = {r_rem, r_rad[RW-1 -: 2]};
    w_sub      = TW'({r_root, 2'b01});
    w_ge       = (w_trial >= w_sub);
    w_rem_nxt  = w_ge ? REMW'(w_trial - w_sub) : REMW'(w_trial);
    w_root_nxt = {r_root, w_ge};
  end

  assign o_root_nxt_c = w_root_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rad  <= '0;
      r_rem  <= '0;
      r_root <= '0;
    end else if (i_load) begin
      r_rad  <= {1'b0, i_rad};
      r_rem  <= '0;
      r_root <= '0;
    end else if (i_step) begin
      r_rad  <= r_rad << 2;
      r_rem  <= w_rem_nxt;
      r_root <= w_root_nxt[W-1:0];
    end
  end

endmodule

// File: rtl/hyp_seq_ctrl.sv
// Sequenced floor(sqrt(x*x+y*y)): shift-add squaring of x then y into one accumulator,
// then a bit-serial root. Define HYP_SAT_EN to clip res to 2^W-1 and flag sat.
module hyp_seq_ctrl
  import hyp_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   res,
  output logic         sat,
  output logic         busy
);

  localparam int unsigned AW    = 2 * W + 1;
  localparam int unsigned CNT_W = $clog2(W + 1);

  if ((W < 4) || (W > 16)) begin : g_w_range
    $error("hyp_seq_ctrl: W must lie in 4..16");
  end

  hyp_state_e       r_state;
  hyp_state_e       w_state_nxt;

  logic [AW-1:0]    r_acc;
  logic [AW-1:0]    r_opa;
  logic [W-1:0]     r_opb;
  logic [W-1:0]     r_y;
  logic [CNT_W-1:0] r_cnt;
  logic [W:0]       r_res;
  logic             r_sat;
  logic             r_out_valid;

  logic             w_last_sq;
  logic             w_last_rt;
  logic             w_isq_load;
  logic             w_isq_step;
  logic [AW-1:0]    w_acc_nxt;
  logic [W:0]       w_root;
  logic [W:0]       w_res_nxt;
  logic             w_sat_nxt;

  assign w_last_sq = (r_cnt == CNT_W'(W - 1));
  assign w_last_rt = (r_cnt == CNT_W'(W));

  // Next state and datapath strobes; nothing advances while ena is low.
  always_comb begin
    w_state_nxt = r_state;
    w_isq_load  = 1'b0;
    w_isq_step  = 1'b0;
    if (ena) begin
      unique case (r_state)
        IDLE: if (in_valid) w_state_nxt = SQX;
        SQX:  if (w_last_sq) w_state_nxt = SQY;
        SQY: begin
          w_isq_load = w_last_sq;
          if (w_last_sq) w_state_nxt = SQRT;
        end
        SQRT: begin
          w_isq_step = 1'b1;
          if (w_last_rt) w_state_nxt = DONE;
        end
        DONE: if (r_out_valid && out_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Accumulator input and result shaping for the cycle that finishes the root.
  always_comb begin
    w_acc_nxt = r_acc + (r_opb[0] ? r_opa : AW'(0));
    w_res_nxt = w_root;
    w_sat_nxt = 1'b0;
`ifdef HYP_SAT_EN
    if (w_root[W]) begin
      w_res_nxt = {1'b0, {W{1'b1}}};
      w_sat_nxt = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_y         <= '0;
      r_cnt       <= '0;
      r_res       <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (ena) begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_opa <= AW'(x);
            r_opb <= x;
            r_y   <= y;
            r_acc <= '0;
            r_cnt <= '0;
            r_res <= '0;
            r_sat <= 1'b0;
          end
        end
        SQX, SQY: begin
          r_acc <= w_acc_nxt;
          if (w_last_sq) begin
            // Reload the multiplier pair with y; harmless at the end of SQY.
            r_opa <= AW'(r_y);
            r_opb <= r_y;
            r_cnt <= '0;
          end else begin
            r_opa <= r_opa << 1;
            r_opb <= r_opb >> 1;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        SQRT: begin
          if (w_last_rt) begin
            r_cnt       <= '0;
            r_res       <= w_res_nxt;
            r_sat       <= w_sat_nxt;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  hyp_isqrt #(.W(W)) u_isqrt (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_isq_load),
    .i_rad        (w_acc_nxt),
    .i_step       (w_isq_step),
    .o_root_nxt_c (w_root)
  );

  assign in_ready  = (r_state == IDLE) && ena;
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign res       = r_res;
  assign sat       = r_sat;

endmodule

// File: tb/tb_hyp_seq_ctrl.sv
// Randomized self-checking bench for hyp_seq_ctrl against an arithmetic hypotenuse model.
module tb_hyp_seq_ctrl;

  localparam int unsigned W   = hyp_pkg::W_DEF;
  localparam int unsigned RW  = W + 1;
  localparam int          LAT = int'(hyp_pkg::LAT_DEF);
  localparam int unsigned MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   res;
  logic         sat;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  hyp_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .sat       (sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Integer square root of the sum of squares, optionally clipped.
  function automatic void ref_model(input int unsigned xx, input int unsigned yy,
                                    output logic [W:0] r, output logic s);
    int unsigned sq;
    int unsigned rt;
    sq = xx * xx + yy * yy;
    rt = 0;
    while ((rt + 1) * (rt + 1) <= sq) rt++;
    s = 1'b0;
`ifdef HYP_SAT_EN
    if (rt > MAXV) begin
      rt = MAXV;
      s  = 1'b1;
    end
`endif
    r = RW'(rt);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] xv, input logic [W-1:0] yv);
    x = xv;
    y = yv;
    in_valid = 1'b1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL xfer_ready: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    x = W'($urandom);
    y = W'($urandom);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    repeat (3) step();
    n_vec++;
    if ({out_valid, res, sat, busy} !== {1'b0, RW'(0), 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_outputs: out_valid=%b res=%0d sat=%b busy=%b required 0/0/0/0",
               out_valid, res, sat, busy);
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int cyc;
    send(W'(3), W'(4));
    wait_out(cyc);
    n_vec++;
    if (cyc != LAT) begin
      n_err++;
      $display("FAIL basic_latency: got %0d cycles required %0d", cyc, LAT);
    end
    n_vec++;
    if (res !== RW'(5) || sat !== 1'b0) begin
      n_err++;
      $display("FAIL basic_3_4: res=%0d sat=%b required 5/0", res, sat);
    end
    n_vec++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_done_flags: in_ready=%b busy=%b required 0/1", in_ready, busy);
    end
    release_out();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_corners();
    int unsigned cx [4];
    int unsigned cy [4];
    logic [W:0]  er;
    logic        es;
    int          cyc;
    cx = '{0, 1, MAXV, MAXV};
    cy = '{0, 1, MAXV, 0};
    for (int i = 0; i < 4; i++) begin
      ref_model(cx[i], cy[i], er, es);
      send(W'(cx[i]), W'(cy[i]));
      wait_out(cyc);
      n_vec++;
      if (cyc != LAT || res !== er || sat !== es) begin
        n_err++;
        $display("FAIL corner x=%0d y=%0d: cyc=%0d res=%0d sat=%b required %0d/%0d/%b",
                 cx[i], cy[i], cyc, res, sat, LAT, er, es);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] er;
    logic       es;
    logic [W:0] r0;
    int         cyc;
    logic [W-1:0] xv;
    logic [W-1:0] yv;
    xv = W'($urandom);
    yv = W'($urandom);
    ref_model(int'(xv), int'(yv), er, es);
    send(xv, yv);
    wait_out(cyc);
    n_vec++;
    if (cyc != LAT || res !== er || sat !== es) begin
      n_err++;
      $display("FAIL bp_result: cyc=%0d res=%0d sat=%b required %0d/%0d/%b",
               cyc, res, sat, LAT, er, es);
    end
    r0 = er;
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if (out_valid !== 1'b1 || res !== r0 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d: out_valid=%b res=%0d in_ready=%b required 1/%0d/0",
                 i, out_valid, res, in_ready, r0);
      end
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release_cycle: in_ready=%b required 0", in_ready);
    end
    step();
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_after_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_ena_stall();
    logic [W:0] er;
    logic       es;
    int         cyc;
    logic [W-1:0] xv;
    logic [W-1:0] yv;
    xv = W'($urandom);
    yv = W'($urandom);
    ref_model(int'(xv), int'(yv), er, es);
    send(xv, yv);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      ena = (cyc < 10 || cyc >= 15);
      step();
      cyc++;
    end
    ena = 1'b1;
    n_vec++;
    if (cyc != LAT + 5) begin
      n_err++;
      $display("FAIL stall_latency: got %0d cycles required %0d", cyc, LAT + 5);
    end
    n_vec++;
    if (res !== er || sat !== es) begin
      n_err++;
      $display("FAIL stall_result: res=%0d sat=%b required %0d/%b", res, sat, er, es);
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    int cyc;
    send(W'($urandom), W'($urandom));
    repeat (20) step();
    n_vec++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_pre: busy=%b out_valid=%b required 1/0", busy, out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, out_valid, res, sat} !== {1'b0, 1'b0, RW'(0), 1'b0}) begin
      n_err++;
      $display("FAIL midrst_async: busy=%b out_valid=%b res=%0d sat=%b required 0/0/0/0",
               busy, out_valid, res, sat);
    end
    step();
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_ready: in_ready=%b required 1", in_ready);
    end
    send(W'(6), W'(8));
    wait_out(cyc);
    n_vec++;
    if (cyc != LAT || res !== RW'(10) || sat !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_6_8: cyc=%0d res=%0d sat=%b required %0d/10/0", cyc, res, sat, LAT);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [W:0] qr [$];
    logic       qs [$];
    logic [W:0] er;
    logic       es;
    int         last_t;
    int         n_xfer;
    last_t = -1;
    n_xfer = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    x = W'($urandom);
    y = W'($urandom);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (in_ready === 1'b1 && n_xfer < 3) begin
        ref_model(int'(x), int'(y), er, es);
        qr.push_back(er);
        qs.push_back(es);
        if (last_t >= 0) begin
          n_vec++;
          if (cyc - last_t != LAT + 2) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d cycles required %0d", cyc - last_t, LAT + 2);
          end
        end
        last_t = cyc;
        n_xfer++;
      end
      step();
      x = W'($urandom);
      y = W'($urandom);
      if (out_valid === 1'b1) begin
        n_vec++;
        if (qr.size() == 0) begin
          n_err++;
          $display("FAIL b2b_unexpected: res=%0d with no pending request", res);
        end else begin
          er = qr.pop_front();
          es = qs.pop_front();
          if (res !== er || sat !== es) begin
            n_err++;
            $display("FAIL b2b_result: res=%0d sat=%b required %0d/%b", res, sat, er, es);
          end
        end
      end
      if (n_xfer == 3 && qr.size() == 0) break;
    end
    in_valid = 1'b0;
    n_vec++;
    if (n_xfer != 3 || qr.size() != 0) begin
      n_err++;
      $display("FAIL b2b_count: transfers=%0d pending=%0d required 3/0", n_xfer, qr.size());
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [W:0]   er;
    logic         es;
    int           cyc;
    logic [W-1:0] xv;
    logic [W-1:0] yv;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) step();
      xv = ($urandom_range(0, 3) == 0) ? W'(MAXV) : W'($urandom);
      yv = ($urandom_range(0, 3) == 0) ? W'(MAXV) : W'($urandom);
      ref_model(int'(xv), int'(yv), er, es);
      send(xv, yv);
      wait_out(cyc);
      n_vec++;
      if (cyc != LAT || res !== er || sat !== es) begin
        n_err++;
        $display("FAIL random x=%0d y=%0d: cyc=%0d res=%0d sat=%b required %0d/%0d/%b",
                 xv, yv, cyc, res, sat, LAT, er, es);
      end
      repeat ($urandom_range(0, 3)) step();
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_ena_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hyp_seq_ctrl.md
HYP_SEQ_CTRL -- requirements
Module: hyp_seq_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, meaning operand width in bits; legal range 4..16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ena  input  1  global enable; low freezes all state.
REQ-005 SHALL have port in_valid  input  1  requester offers an operand pair.
REQ-006 SHALL have port in_ready  output  1  block accepts an operand pair this cycle.
REQ-007 SHALL have port x  input  W  first operand, unsigned.
REQ-008 SHALL have port y  input  W  second operand, unsigned.
REQ-009 SHALL have port out_valid  output  1  res is valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes res.
REQ-011 SHALL have port res  output  W+1  floor(sqrt(x*x+y*y)), unsigned.
REQ-012 SHALL have port sat  output  1  result clipped; constant 0 unless HYP_SAT_EN is defined.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SQX, SQY, SQRT, DONE, sequencing one shared shift-add accumulator and one bit-serial square-root unit.
REQ-015 SHALL assert in_ready only in IDLE with ena high; a transfer occurs on a rising edge with in_valid, in_ready and ena all high.
REQ-016 SHALL, on transfer, register x and y, clear the 2W+1-bit accumulator and enter SQX.
REQ-017 SHALL spend exactly W cycles in SQX, adding x shifted left by i when bit i of x is 1, then enter SQY.
REQ-018 SHALL spend exactly W cycles in SQY, adding y*y in the same way into the same accumulator, then enter SQRT.
REQ-019 SHALL spend exactly W+1 cycles in SQRT, producing one result bit per cycle, MSB first, by restoring digit recurrence on the 2W+1-bit radicand, then enter DONE.
REQ-020 SHALL raise out_valid on the first cycle of DONE: 3W+1 enabled edges after the transfer edge (25 for W=8).
REQ-021 SHALL hold res and out_valid stable in DONE until out_valid and out_ready are both high on an enabled edge, then return to IDLE.
REQ-022 SHALL NOT assert in_ready in DONE, including on the release cycle; back-to-back throughput is one result per 3W+3 cycles.
REQ-023 SHALL freeze every register and the cycle count while ena is low; handshakes are not honoured while ena is low.
REQ-024 SHALL never overflow: accumulator maximum is 2*(2^W-1)^2, which is below 2^(2W+1); the result maximum fits W+1 bits.
REQ-025 SHALL ignore x and y changes after the transfer edge.

Reset
REQ-026 SHALL, on rst_n low at any time, including mid-operation, enter IDLE asynchronously, clear the operand, accumulator and result registers, and drive out_valid=0, res=0, sat=0, busy=0.
REQ-027 SHALL drive in_ready=1 on the first enabled cycle after rst_n deasserts.

Configuration
REQ-028 SHALL, with HYP_SAT_EN defined, clip res to 2^W-1 and set sat=1 when the true result is at least 2^W; res[W] is then always 0.
REQ-029 SHALL, without HYP_SAT_EN, output the full W+1-bit result and tie sat to 0.

Structure
REQ-030 SHALL take the state enum, default W and the latency constant (3W+1) from shared package hyp_pkg.
REQ-031 SHALL instantiate one sub-module hyp_isqrt (bit-serial restoring square root with start/step control from the FSM); squaring stays in hyp_seq_ctrl.

Verification
REQ-032 Bench SHALL cover: x=3, y=4 accepted -> out_valid exactly 25 cycles later, res=5, sat=0.
REQ-033 Bench SHALL cover: x=0, y=0 -> res=0; x=1, y=1 -> res=1.
REQ-034 Bench SHALL cover: x=255, y=255 -> res=360, sat=0; with HYP_SAT_EN -> res=255, sat=1.
REQ-035 Bench SHALL cover: out_ready held low for 10 cycles in DONE -> res and out_valid stable, in_ready=0; one cycle after release -> in_ready=1.
REQ-036 Bench SHALL cover: ena low for 5 cycles during SQY -> out_valid at 30 cycles, correct result.
REQ-037 Bench SHALL cover: rst_n pulsed low during SQRT -> immediate IDLE, out_valid=0, next x=6, y=8 yields res=10.
